// File: rtl/reduce_adder_sched.sv
// Round-robin scheduler sharing one pipelined FP adder among reduction-table slots.
// Optional single-cycle AND/OR/MAX bypass ALU enabled by defining REDUCE_BYPASS_EN.
module reduce_adder_sched #(
  parameter int NumReq    = 4,
  parameter int IdxWidth  = 2,
  parameter int DataWidth = 32,
  parameter int OpWidth   = 4,
  parameter int Latency   = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NumReq-1:0]           req,
  input  logic [NumReq*DataWidth-1:0] req_a,
  input  logic [NumReq*DataWidth-1:0] req_b,
  input  logic [NumReq*OpWidth-1:0]   req_op,
  output logic [NumReq-1:0]           grant,
  output logic [NumReq-1:0]           busy,
  output logic [DataWidth-1:0]        add_a,
  output logic [DataWidth-1:0]        add_b,
  input  logic [DataWidth-1:0]        add_sum,
  output logic                        wb_valid,
  output logic [IdxWidth-1:0]         wb_idx,
  output logic [DataWidth-1:0]        wb_data
);

  logic [IdxWidth-1:0]  rr;
  logic [Latency-1:0]   vpipe;
  logic [IdxWidth-1:0]  ipipe [Latency];
  logic [NumReq-1:0]    elig;
  logic [NumReq-1:0]    blocked;
  logic [NumReq-1:0]    wb_clr;
  logic [IdxWidth-1:0]  gidx;
  logic [IdxWidth-1:0]  cand;
  logic                 found;
  logic                 byp_grant;
  logic                 adder_fire;
  logic [DataWidth-1:0] sel_a;
  logic [DataWidth-1:0] sel_b;

`ifdef REDUCE_BYPASS_EN
  logic [OpWidth-1:0]   sel_op;
  logic                 byp_valid;
  logic [IdxWidth-1:0]  byp_idx;
  logic [DataWidth-1:0] byp_data;
  logic [DataWidth-1:0] alu_res;

  function automatic logic is_byp(input logic [OpWidth-1:0] op);
    return (op == OpWidth'(1)) || (op == OpWidth'(2)) || (op == OpWidth'(3));
  endfunction

  // Bypass ops yield to an adder result landing in the following cycle.
  always_comb begin
    blocked = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      blocked[i] = vpipe[Latency-2] && is_byp(req_op[i*OpWidth +: OpWidth]);
    end
  end

  assign sel_op    = req_op[gidx*OpWidth +: OpWidth];
  assign byp_grant = found && is_byp(sel_op);

  always_comb begin
    alu_res = '0;
    case (sel_op)
      OpWidth'(1): alu_res = sel_a & sel_b;
      OpWidth'(2): alu_res = sel_a | sel_b;
      OpWidth'(3): alu_res = (sel_a > sel_b) ? sel_a : sel_b;
      default:     alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_valid <= 1'b0;
      byp_idx   <= '0;
      byp_data  <= '0;
    end else begin
      byp_valid <= byp_grant;
      byp_idx   <= gidx;
      byp_data  <= alu_res;
    end
  end

  assign wb_valid = vpipe[Latency-1] | byp_valid;
  assign wb_idx   = byp_valid ? byp_idx : ipipe[Latency-1];
  assign wb_data  = byp_valid ? byp_data : (vpipe[Latency-1] ? add_sum : '0);
`else
  logic unused_op;
  assign unused_op = ^req_op;
  assign blocked   = '0;
  assign byp_grant = 1'b0;
  assign wb_valid  = vpipe[Latency-1];
  assign wb_idx    = ipipe[Latency-1];
  assign wb_data   = vpipe[Latency-1] ? add_sum : '0;
`endif

  assign elig = req & ~busy & ~blocked;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = rr + IdxWidth'(k);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  assign sel_a      = req_a[gidx*DataWidth +: DataWidth];
  assign sel_b      = req_b[gidx*DataWidth +: DataWidth];
  assign adder_fire = found && !byp_grant;
  assign grant      = found ? (NumReq'(1) << gidx) : '0;
  assign add_a      = adder_fire ? sel_a : '0;
  assign add_b      = adder_fire ? sel_b : '0;
  assign wb_clr     = wb_valid ? (NumReq'(1) << wb_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr    <= '0;
      vpipe <= '0;
      busy  <= '0;
      for (int unsigned i = 0; i < Latency; i++) ipipe[i] <= '0;
    end else begin
      vpipe    <= {vpipe[Latency-2:0], adder_fire};
      ipipe[0] <= gidx;
      for (int unsigned i = 1; i < Latency; i++) ipipe[i] <= ipipe[i-1];
      busy     <= (busy & ~wb_clr) | grant;
      if (found) rr <= gidx + IdxWidth'(1);
    end
  end

endmodule

// File: tb/tb_reduce_adder_sched.sv
// Scoreboard bench for reduce_adder_sched with a behavioural 14-cycle FP adder stub.
module tb_reduce_adder_sched;
  localparam int NumReq = 4, IdxWidth = 2, DataWidth = 32, OpWidth = 4, Latency = 14;

  logic clk = 1'b0;
  logic rst;
  logic [NumReq-1:0]           req;
  logic [NumReq*DataWidth-1:0] req_a, req_b;
  logic [NumReq*OpWidth-1:0]   req_op;
  logic [NumReq-1:0]           grant, busy;
  logic [DataWidth-1:0]        add_a, add_b, add_sum, wb_data;
  logic                        wb_valid;
  logic [IdxWidth-1:0]         wb_idx;

  reduce_adder_sched #(.NumReq(NumReq), .IdxWidth(IdxWidth), .DataWidth(DataWidth),
                       .OpWidth(OpWidth), .Latency(Latency)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .grant(grant), .busy(busy), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data));

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'({3'b000, f[30:23]}) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Adder IP stub: fixed latency, never reset.
  logic [31:0] apipe [Latency];
  always @(posedge clk) begin
    apipe[0] <= r2f(f2r(add_a) + f2r(add_b));
    for (int i = 1; i < Latency; i++) apipe[i] <= apipe[i-1];
  end
  assign add_sum = apipe[Latency-1];

  typedef struct { logic [IdxWidth-1:0] idx; logic [DataWidth-1:0] data; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Results may return out of grant order (bypass), so match on slot index.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      int pos;
      pos = -1;
      for (int i = 0; i < sb.size(); i++) if (pos < 0 && sb[i].idx == wb_idx) pos = i;
      checks++;
      if (pos < 0) begin
        failures++;
        $display("FAIL wb_unexpected idx=%0d data=%h required=no write-back", wb_idx, wb_data);
      end else begin
        if (wb_data !== sb[pos].data) begin
          failures++;
          $display("FAIL wb_data idx=%0d got=%h required=%h", wb_idx, wb_data, sb[pos].data);
        end
        sb.delete(pos);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_slot(input int s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[s*OpWidth +: OpWidth] = op;
    req_a[s*DataWidth +: DataWidth] = a;
    req_b[s*DataWidth +: DataWidth] = b;
  endtask

  task automatic push(input int idx, input logic [31:0] data);
    exp_t e;
    e.idx = IdxWidth'(idx);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick(); tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin tick(); n++; end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    tick();
  endtask

  task automatic test_reset();
    req_a = '0; req_b = '0; req_op = '0;
    do_reset();
    @(negedge clk);
    checks++;
    if (busy !== '0 || wb_valid !== 1'b0 || grant !== '0 || add_a !== '0 || wb_data !== '0) begin
      failures++;
      $display("FAIL reset busy=%b wb_valid=%b grant=%b add_a=%h wb_data=%h required all 0",
               busy, wb_valid, grant, add_a, wb_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_slot(0, 4'hF, 32'h3F800000, 32'h40000000);
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || add_a !== 32'h3F800000 || add_b !== 32'h40000000) begin
      failures++;
      $display("FAIL single_grant grant=%b a=%h b=%h required 0001 3f800000 40000000", grant, add_a, add_b);
    end
    push(0, 32'h40400000);
    tick(); req = '0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== ((c <= 14) ? 4'b0001 : 4'b0000) || wb_valid !== (c == 14)) begin
        failures++;
        $display("FAIL single_c%0d busy=%b wb_valid=%b", c, busy, wb_valid);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] sums [4];
    logic [3:0] eg;
    sums[0] = 32'h40000000; sums[1] = 32'h40400000; sums[2] = 32'h40800000; sums[3] = 32'h40A00000;
    do_reset();
    set_slot(0, 4'hF, 32'h3F800000, 32'h3F800000);
    set_slot(1, 4'hF, 32'h40000000, 32'h3F800000);
    set_slot(2, 4'hF, 32'h40400000, 32'h3F800000);
    set_slot(3, 4'hF, 32'h40800000, 32'h3F800000);
    req = 4'b1111;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      eg = (c < 4) ? (4'b0001 << c) : ((c == 15) ? 4'b0001 : 4'b0000);
      checks++;
      if (grant !== eg || wb_valid !== (c >= 14 && c <= 17)) begin
        failures++;
        $display("FAIL b2b_c%0d grant=%b required=%b wb_valid=%b", c, grant, eg, wb_valid);
      end
      if (c < 4) push(c, sums[c]);
      if (c == 15) push(0, sums[0]);
      tick();
      if (c == 15) req = '0;
    end
    drain();
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    set_slot(0, 4'hF, 32'h40000000, 32'h40000000);
    set_slot(1, 4'hF, 32'h3F800000, 32'h3F800000);
    set_slot(3, 4'hF, 32'h40400000, 32'h3F800000);
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_first grant=%b required=0010", grant);
    end
    push(1, 32'h40000000);
    tick(); req = '0;
    n = 0;
    while (busy !== '0 && n < 30) begin tick(); n++; end
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_grant grant=%b required=0001", grant);
    end
    push(0, 32'h40800000);
    tick(); req = 4'b1010;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_rr_next grant=%b required=0010", grant);
    end
    push(1, 32'h40000000);
    tick(); req = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_slot(1, 4'hF, 32'h3F800000, 32'h40000000);
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL rstmid_grant grant=%b required=0010", grant);
    end
    tick(); req = '0;
    for (int c = 1; c <= 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    for (int c = 6; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== '0 || wb_valid !== 1'b0 || grant !== '0) begin
        failures++;
        $display("FAIL rstmid_c%0d busy=%b wb_valid=%b grant=%b required 0", c, busy, wb_valid, grant);
      end
      tick();
    end
  endtask

`ifdef REDUCE_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    set_slot(2, 4'h3, 32'd5, 32'd9);
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || add_a !== '0 || add_b !== '0 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL byp_grant grant=%b add_a=%h add_b=%h wb_valid=%b", grant, add_a, add_b, wb_valid);
    end
    push(2, 32'd9);
    tick(); req = '0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_idx !== 2'd2) begin
      failures++;
      $display("FAIL byp_wb wb_valid=%b idx=%0d required 1 2", wb_valid, wb_idx);
    end
    tick();
    set_slot(0, 4'h1, 32'h0000F0F0, 32'h0000FF00);
    set_slot(1, 4'h2, 32'h000000F0, 32'h00000F00);
    req = 4'b0011;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== (c >= 1)) begin
        failures++;
        $display("FAIL byp_andor_c%0d wb_valid=%b", c, wb_valid);
      end
      if (c == 0) push(0, 32'h0000F000);
      if (c == 1) push(1, 32'h00000FF0);
      tick();
      if (c == 1) req = '0;
    end
    drain();
  endtask

  task automatic test_collision();
    logic [3:0] eg;
    do_reset();
    set_slot(0, 4'hF, 32'h3F800000, 32'h40000000);
    set_slot(2, 4'h1, 32'h000000FF, 32'h0000000F);
    set_slot(3, 4'hF, 32'h40000000, 32'h40000000);
    req = 4'b0001;
    @(negedge clk);
    push(0, 32'h40400000);
    tick(); req = '0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 13) req = 4'b1100;
      if (c == 14) req = 4'b0100;
      if (c == 15) req = '0;
      @(negedge clk);
      eg = (c == 13) ? 4'b1000 : ((c == 14) ? 4'b0100 : 4'b0000);
      checks++;
      if (grant !== eg || wb_valid !== (c == 14 || c == 15)) begin
        failures++;
        $display("FAIL coll_c%0d grant=%b required=%b wb_valid=%b", c, grant, eg, wb_valid);
      end
      if (c == 14 || c == 15) begin
        checks++;
        if (wb_idx !== ((c == 14) ? 2'd0 : 2'd2)) begin
          failures++;
          $display("FAIL coll_idx_c%0d got=%0d required=%0d", c, wb_idx, (c == 14) ? 0 : 2);
        end
      end
      if (c == 13) push(3, 32'h40800000);
      if (c == 14) push(2, 32'h0000000F);
      tick();
    end
    drain();
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`ifdef REDUCE_BYPASS_EN
    test_bypass();
    test_collision();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reduce_adder_sched.md
# reduce_adder_sched

Round-robin scheduler that shares one pipelined floating-point adder between the reduction-table slots of a reduction unit. Each slot raises a request carrying two operands and an op code. The block grants one slot per cycle and drives the adder inputs. It tracks the granted slot index through a fixed-latency valid/index pipeline and presents each result, tagged with its slot index, for write-back into the reduction table. It sits between the reduction table and the adder IP core.

## Interface
Parameters:
- NumReq, 4, number of requesting reduction-table slots (power of two, ≥2)
- IdxWidth, 2, log2(NumReq)
- DataWidth, 32, operand/result width (single-precision float)
- OpWidth, 4, op code width
- Latency, 14, adder latency in cycles (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NumReq  per-slot request, held until granted
- req_a  in  NumReq*DataWidth  operand A, slot i at [i*DataWidth +: DataWidth]
- req_b  in  NumReq*DataWidth  operand B, same packing
- req_op  in  NumReq*OpWidth  op code, slot i at [i*OpWidth +: OpWidth]
- grant  out  NumReq  one-hot grant, combinational, at most one bit set
- busy  out  NumReq  slot i has an operation in flight
- add_a  out  DataWidth  adder input A
- add_b  out  DataWidth  adder input B
- add_sum  in  DataWidth  adder output, valid exactly Latency cycles after inputs are applied
- wb_valid  out  1  write-back strobe, one cycle
- wb_idx  out  IdxWidth  slot index of the write-back
- wb_data  out  DataWidth  result

## Operation
- Eligible set: `req & ~busy`.
- Arbitration:
  - Round-robin pointer `rr` (IdxWidth bits).
  - Grant the first eligible slot searching from `rr` upward with wrap.
  - After granting slot g, `rr <= g+1` (mod NumReq).
  - `rr` is unchanged when nothing is granted.
- Adder drive:
  - When granted, `add_a`/`add_b` = granted slot's operands in the same cycle.
  - Otherwise `add_a`/`add_b` = 0.
- Tracking:
  - Shift pipeline `vpipe[Latency-1:0]` holds valid bits; `ipipe` holds the index per stage.
  - An adder grant loads stage 0 at the clock edge; every stage shifts each cycle.
- Busy:
  - `busy[g]` is set at the grant edge.
  - `busy[g]` is cleared at the edge ending the write-back cycle of slot g.
  - A busy slot is never granted, so there is no read-after-write hazard on table entries.
- Write-back:
  - `wb_valid = vpipe[Latency-1]`, `wb_idx = ipipe[Latency-1]`, `wb_data = add_sum`.
  - All three are combinational from pipeline state.
- Without `REDUCE_BYPASS_EN`, every op code, including 4'b1111 (add), is routed to the adder.
- Reset (including mid-operation): clears `vpipe`, `busy` and `rr`, and discards in-flight results. Adder output arriving after reset is ignored. All outputs read 0 in the cycle following reset.

## Timing
- Grant in cycle t → `wb_valid` in cycle t+Latency → `busy` clear from cycle t+Latency+1.
- Throughput: one grant per cycle; with all NumReq slots busy, no grant is issued.
- A slot can re-request in cycle t+Latency+1 at the earliest.
- Simultaneous write-back of slot i and request from slot i: not eligible that cycle (still busy).
- `req` dropped before grant: no effect, no state.

## Configuration
- Macro `REDUCE_BYPASS_EN`. When defined, it adds a single-cycle local ALU for ops 4'b0001 (bitwise AND), 4'b0010 (bitwise OR) and 4'b0011 (unsigned max); all other ops still use the adder.
- Bypass path:
  - A bypass grant in cycle t registers the result and its index.
  - `wb_valid` is asserted in cycle t+1 with the bypass result.
  - `add_a`/`add_b` = 0 for bypass grants.
- Collision rule: a bypass request is ineligible in any cycle where `vpipe[Latency-2]` = 1, so the adder write-back always owns cycle t+1. The round-robin search then skips that slot and continues to the next eligible slot.
- Without the macro: no bypass logic, and `wb_data` always comes from `add_sum`.

## Test plan
- Reset, then `req`=4'b0001, op 4'b1111, a=0x3F800000, b=0x40000000 → `grant`=4'b0001 in cycle 0; `wb_valid`, `wb_idx`=0, `wb_data`=0x40400000 in cycle 14; `busy[0]` high cycles 1-14.
- `req`=4'b1111 held continuously → grants 0,1,2,3 in cycles 0-3; write-backs for 0,1,2,3 in cycles 14-17; no grant in cycles 4-14; slot 0 regranted in cycle 15.
- `rr`=2 after a grant to slot 1, then `req`=4'b0011 → slot 0 granted (wrap); `rr` becomes 1.
- Slot 1 granted in cycle 0, then `rst` pulsed in cycle 5 → `busy`=0 and `wb_valid` stays 0 through cycle 20 despite adder output.
- `REDUCE_BYPASS_EN`: slot 2 op 4'b0011, a=5, b=9 → `wb_valid`, `wb_idx`=2, `wb_data`=9 next cycle.
- `REDUCE_BYPASS_EN`: adder grant in cycle 0, bypass request in cycle 13 → bypass blocked in cycle 13, granted in cycle 14, write-back in cycle 15; adder write-back in cycle 14 unaffected.
